// File: rtl/expr_pkg.sv
// Shared constants and FSM state type for the ASCII expression stream (transmitter and recognizer).
package expr_pkg;

  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NUL    = 8'h00;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_TENS,
    S_ONES,
    S_OPER,
    S_CLOSE,
    S_TERM,
    S_FIN
  } tx_state_e;

endpackage

// File: rtl/expr_stream_tx_bin2dec99.sv
// bin2dec99: clamps an operand to 0..99 and splits it into tens/ones digits without a divider.
module bin2dec99 #(
  parameter int unsigned OPW = 7
) (
  input  logic [OPW-1:0] val,
  output logic [3:0]     tens,
  output logic [3:0]     ones
);

  logic [6:0] clamped;

  always_comb begin
    clamped = (32'(val) > 32'd99) ? 7'd99 : 7'(val);
    tens    = '0;
    for (int unsigned k = 1; k <= 9; k++) begin
      if (clamped >= 7'(10 * k)) tens = 4'(k);
    end
    ones = 4'(clamped - 7'(10 * tens));
  end

endmodule

// File: rtl/expr_stream_tx.sv
// expr_stream_tx: serializes a latched operand/operator descriptor into an ASCII expression,
// one character per ready/valid transfer. Define EXPR_TX_NUL_TERM_EN to append a NUL terminator.
module expr_stream_tx
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 4,
  parameter int unsigned OPW       = 7
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [2:0]               num_terms,
  input  logic [MAX_TERMS*OPW-1:0] operands,
  input  logic [MAX_TERMS-2:0]     ops,
  input  logic                     paren,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IW = $clog2(MAX_TERMS) + 1;

`ifdef EXPR_TX_NUL_TERM_EN
  localparam tx_state_e AFTER_LAST = S_TERM;
`else
  localparam tx_state_e AFTER_LAST = S_FIN;
`endif

  tx_state_e                state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [2:0]               num_q, num_d;
  logic [MAX_TERMS*OPW-1:0] operands_q, operands_d;
  logic [MAX_TERMS-2:0]     ops_q, ops_d;
  logic                     paren_q, paren_d;
  logic                     err_q, err_d;

  logic [IW-1:0]  sel_idx;
  logic [OPW-1:0] sel_val;
  logic [3:0]     tens, ones, ones_eff;
  logic           op_bit, more_terms, start_ok;
  tx_state_e      digit_next;

  // OPER already looks ahead to the next term so it can skip TENS for single-digit values;
  // in IDLE the live input is decoded because nothing is latched yet.
  always_comb begin
    sel_idx = (state_q == S_OPER) ? idx_q + IW'(1) : idx_q;
    sel_val = '0;
    op_bit  = OP_ADD;
    if (state_q == S_IDLE) begin
      sel_val = operands[OPW-1:0];
    end else begin
      for (int unsigned i = 0; i < MAX_TERMS; i++) begin
        if (IW'(i) == sel_idx) sel_val = operands_q[i*OPW +: OPW];
      end
    end
    for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
      if (IW'(i) == idx_q) op_bit = ops_q[i];
    end
  end

  bin2dec99 #(.OPW(OPW)) u_bin2dec99 (
    .val  (sel_val),
    .tens (tens),
    .ones (ones)
  );

  always_comb begin
    ones_eff   = (paren_q && idx_q == '0 && tens == '0 && ones == '0) ? 4'd1 : ones;
    more_terms = (32'(idx_q) + 32'd1) < 32'(num_q);
    start_ok   = (num_terms != 3'd0) && (32'(num_terms) <= MAX_TERMS);
    digit_next = (tens != '0) ? S_TENS : S_ONES;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    num_d      = num_q;
    operands_d = operands_q;
    ops_d      = ops_q;
    paren_d    = paren_q;
    err_d      = 1'b0;
    out_byte   = CH_NUL;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (start_ok) begin
            num_d      = num_terms;
            operands_d = operands;
            ops_d      = ops;
            paren_d    = paren;
            idx_d      = '0;
            state_d    = paren ? S_OPEN : digit_next;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_OPEN: begin
        out_valid = 1'b1;
        out_byte  = CH_LPAREN;
        if (out_ready) state_d = digit_next;
      end
      S_TENS: begin
        out_valid = 1'b1;
        out_byte  = CH_ZERO + {4'b0, tens};
        if (out_ready) state_d = S_ONES;
      end
      S_ONES: begin
        out_valid = 1'b1;
        out_byte  = CH_ZERO + {4'b0, ones_eff};
        if (out_ready) begin
          if (more_terms)   state_d = S_OPER;
          else if (paren_q) state_d = S_CLOSE;
          else              state_d = AFTER_LAST;
        end
      end
      S_OPER: begin
        out_valid = 1'b1;
        out_byte  = (op_bit == OP_MUL) ? CH_STAR : CH_PLUS;
        if (out_ready) begin
          idx_d   = idx_q + IW'(1);
          state_d = digit_next;
        end
      end
      S_CLOSE: begin
        out_valid = 1'b1;
        out_byte  = CH_RPAREN;
        if (out_ready) state_d = AFTER_LAST;
      end
      S_TERM: begin
        out_valid = 1'b1;
        out_byte  = CH_NUL;
        if (out_ready) state_d = S_FIN;
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      num_q      <= '0;
      operands_q <= '0;
      ops_q      <= '0;
      paren_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      operands_q <= operands_d;
      ops_q      <= ops_d;
      paren_q    <= paren_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_expr_stream_tx.sv
// Self-checking bench for expr_stream_tx: expected frames are built from the textual expression rules.
module tb_expr_stream_tx;

  localparam int MT = 4;
  localparam int OW = 7;
`ifdef EXPR_TX_NUL_TERM_EN
  localparam bit NUL_EN = 1'b1;
`else
  localparam bit NUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, start, paren, out_ready;
  logic [2:0]  num_terms;
  logic [27:0] operands;
  logic [2:0]  ops;
  logic [7:0]  out_byte;
  logic        out_valid, busy, done, err;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  expr_stream_tx #(.MAX_TERMS(MT), .OPW(OW)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .num_terms (num_terms),
    .operands  (operands),
    .ops       (ops),
    .paren     (paren),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic build_expected(input int n, input logic [27:0] opnd, input logic [2:0] opv,
                                input logic par);
    int v;
    exp_q.delete();
    if (par) exp_q.push_back(8'h28);
    for (int i = 0; i < n; i++) begin
      v = int'(opnd[i*7 +: 7]);
      if (v > 99) v = 99;
      if (i == 0 && par && v == 0) v = 1;
      if (v >= 10) exp_q.push_back(8'(48 + v / 10));
      exp_q.push_back(8'(48 + v % 10));
      if (i < n - 1) exp_q.push_back(opv[i] ? 8'h2A : 8'h2B);
    end
    if (par) exp_q.push_back(8'h29);
    if (NUL_EN) exp_q.push_back(8'h00);
  endtask

  // mode 0: always ready, 1: random ready, 2: repeating 1,0,0,1 pattern
  task automatic run_frame(input string name, input int n, input logic [27:0] opnd,
                           input logic [2:0] opv, input logic par, input int mode,
                           input bit poke_start);
    int k, cyc;
    logic [7:0] held;
    bit stalled;
    build_expected(n, opnd, opv, par);
    @(negedge clk);
    start = 1'b1; num_terms = 3'(n); operands = opnd; ops = opv; paren = par; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    operands = 28'($urandom); ops = 3'($urandom); paren = ~par; num_terms = 3'($urandom);
    ntests++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    k = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while (k < exp_q.size() && cyc < 200) begin
      ntests++;
      if (out_valid !== 1'b1) begin
        nfail++; $display("FAIL %s valid[%0d]: got %b expected 1", name, k, out_valid);
      end
      ntests++;
      if (out_byte !== exp_q[k]) begin
        nfail++; $display("FAIL %s byte[%0d]: got %h expected %h", name, k, out_byte, exp_q[k]);
      end
      ntests++;
      if (err !== 1'b0) begin
        nfail++; $display("FAIL %s err_in_frame: got %b expected 0", name, err);
      end
      if (stalled) begin
        ntests++;
        if (out_byte !== held) begin
          nfail++; $display("FAIL %s hold[%0d]: got %h expected %h", name, k, out_byte, held);
        end
      end
      held = out_byte;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      start     = (poke_start && cyc == 1);
      num_terms = poke_start ? 3'd0 : num_terms;
      stalled   = !out_ready;
      if (out_ready && out_valid === 1'b1) k++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b0;
    ntests++;
    if (cyc >= 200) begin
      nfail++; $display("FAIL %s timeout: got %0d bytes expected %0d", name, k, exp_q.size());
    end
    ntests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL %s fin: got done=%b busy=%b valid=%b err=%b expected 1 0 0 0",
               name, done, busy, out_valid, err);
    end
    @(negedge clk);
    ntests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; paren = 1'b0; out_ready = 1'b0;
    num_terms = 3'd0; operands = '0; ops = '0;
    repeat (2) @(negedge clk);
    ntests++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL reset: got valid=%b byte=%h busy=%b done=%b err=%b expected 0 00 0 0 0",
               out_valid, out_byte, busy, done, err);
    end
    clr = 1'b0;
  endtask

  task automatic test_reject(input logic [2:0] n);
    @(negedge clk);
    start = 1'b1; num_terms = n;
    @(negedge clk);
    start = 1'b0;
    ntests++;
    if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reject_%0d: got err=%b busy=%b valid=%b expected 1 0 0", n, err, busy, out_valid);
    end
    @(negedge clk);
    ntests++;
    if (err !== 1'b0) begin
      nfail++; $display("FAIL reject_pulse_%0d: got err=%b expected 0", n, err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; num_terms = 3'd2; operands = {14'd0, 7'd2, 7'd1}; ops = 3'b000; paren = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    ntests++;
    if (out_byte !== 8'h31) begin
      nfail++; $display("FAIL mid_reset_progress: got %h expected 31", out_byte);
    end
    @(negedge clk);
    clr = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    ntests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_byte !== 8'h00) begin
      nfail++;
      $display("FAIL mid_reset: got valid=%b busy=%b done=%b byte=%h expected 0 0 0 00",
               out_valid, busy, done, out_byte);
    end
    run_frame("after_reset", 2, {14'd0, 7'd45, 7'd8}, 3'b001, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [27:0] o;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 4; i++) o[i*7 +: 7] = 7'($urandom_range(0, 127));
      run_frame("random", int'($urandom_range(1, 4)), o, 3'($urandom), 1'($urandom), 1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_frame("single_57", 1, {21'd0, 7'd57}, 3'b000, 1'b0, 0, 1'b0);
    run_frame("bracketed_mix", 3, {7'd0, 7'd99, 7'd0, 7'd12}, 3'b010, 1'b1, 0, 1'b0);
    run_frame("clamp_lead", 2, {14'd0, 7'd120, 7'd0}, 3'b001, 1'b1, 0, 1'b0);
    run_frame("single_7", 1, {21'd0, 7'd7}, 3'b000, 1'b0, 0, 1'b0);
    run_frame("backpressure", 2, {14'd0, 7'd4, 7'd3}, 3'b000, 1'b1, 2, 1'b0);
    test_reject(3'd0);
    test_reject(3'd5);
    test_reject(3'd7);
    run_frame("start_while_busy", 4, {7'd100, 7'd9, 7'd10, 7'd0}, 3'b101, 1'b0, 2, 1'b1);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
